// File: rtl/tt_um_uart_mvm.sv
// UART-attached signed matrix-vector multiplier for TinyTapeout.
// The chip receives a packed K matrix and x vector as bytes and returns y = K*x one byte per row.

module uart_rx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] data,
    output logic                     valid
);
    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W = $clog2(BITS_PER_WORD);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state;
    rx_state_t        state_next;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_idx;
    logic             half_done;
    logic             pulse_done;

    assign half_done  = (cnt == CNT_W'(CLOCKS_PER_PULSE / 2 - 1));
    assign pulse_done = (cnt == CNT_W'(CLOCKS_PER_PULSE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state   <= RX_IDLE;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            state   <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (!rx_sync) state_next = RX_START;
            RX_START: if (half_done) state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (pulse_done && bit_idx == BIT_W'(BITS_PER_WORD - 1)) state_next = RX_STOP;
            RX_STOP:  if (pulse_done) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // START re-centres the counter on mid-bit so DATA samples each bit at its centre.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                RX_START: cnt <= half_done ? '0 : cnt + 1'b1;
                RX_DATA: begin
                    if (pulse_done) begin
                        cnt     <= '0;
                        data    <= {rx_sync, data[BITS_PER_WORD-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    cnt <= cnt + 1'b1;
                    if (pulse_done) valid <= 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

module mvm #(
    parameter int R       = 2,
    parameter int C       = 2,
    parameter int W_X     = 4,
    parameter int W_K     = 4,
    parameter int W_Y_OUT = 8
) (
    input  logic [R*C*W_K+C*W_X-1:0] bus,
    output logic [R*W_Y_OUT-1:0]     y
);
    localparam int W_PROD   = W_X + W_K;
    localparam int W_Y_FULL = W_X + W_K + $clog2(C);

    logic signed [W_PROD-1:0]   prod;
    logic signed [W_Y_FULL-1:0] acc;

    // Only the low W_Y_OUT bits leave the chip, so rows wrap modulo 2^W_Y_OUT.
    always_comb begin
        y    = '0;
        prod = '0;
        acc  = '0;
        for (int r = 0; r < R; r++) begin
            acc = '0;
            for (int c = 0; c < C; c++) begin
                prod = $signed(bus[C*W_X + r*C*W_K + c*W_K +: W_K]) * $signed(bus[c*W_X +: W_X]);
                acc  = acc + W_Y_FULL'(prod);
            end
            y[r*W_Y_OUT +: W_Y_OUT] = acc[W_Y_OUT-1:0];
        end
    end
endmodule

module uart_tx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int N_WORDS          = 2,
    parameter int PACKET_SIZE_TX   = 13
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [N_WORDS*BITS_PER_WORD-1:0] words,
    output logic                             busy,
    output logic                             tx
);
    localparam int CNT_W  = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W  = $clog2(PACKET_SIZE_TX);
    localparam int WORD_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t                        state;
    tx_state_t                        state_next;
    logic [N_WORDS*BITS_PER_WORD-1:0] buffer;
    logic [CNT_W-1:0]                 cnt;
    logic [BIT_W-1:0]                 bit_idx;
    logic [WORD_W-1:0]                word_idx;
    logic [BITS_PER_WORD-1:0]         cur_word;
    logic [PACKET_SIZE_TX-1:0]        frame;
    logic                             pulse_done;
    logic                             last_bit;
    logic                             last_word;

    assign pulse_done = (cnt == CNT_W'(CLOCKS_PER_PULSE - 1));
    assign last_bit   = (bit_idx == BIT_W'(PACKET_SIZE_TX - 1));
    assign last_word  = (word_idx == WORD_W'(N_WORDS - 1));
    assign busy       = (state != TX_IDLE);

    always_comb begin
        cur_word = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (word_idx == WORD_W'(w)) cur_word = buffer[w*BITS_PER_WORD +: BITS_PER_WORD];
        end
        frame = {{(PACKET_SIZE_TX - BITS_PER_WORD - 1){1'b1}}, cur_word, 1'b0};
        tx    = (state == TX_SEND) ? frame[bit_idx] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE: if (load) state_next = TX_SEND;
            TX_SEND: if (pulse_done && last_bit && last_word) state_next = TX_IDLE;
            default: state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer   <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            word_idx <= '0;
        end else if (state == TX_IDLE) begin
            cnt      <= '0;
            bit_idx  <= '0;
            word_idx <= '0;
            if (load) buffer <= words;
        end else if (pulse_done) begin
            cnt <= '0;
            if (last_bit) begin
                bit_idx  <= '0;
                word_idx <= word_idx + 1'b1;
            end else begin
                bit_idx <= bit_idx + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module tt_um_uart_mvm #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int R                = 2,
    parameter int C                = 2,
    parameter int W_X              = 4,
    parameter int W_K              = 4,
    parameter int W_Y_OUT          = 8,
    parameter int PACKET_SIZE_TX   = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int N_BITS     = R*C*W_K + C*W_X;
    localparam int N_WORDS_KX = N_BITS / BITS_PER_WORD;
    localparam int N_WORDS_Y  = R*W_Y_OUT / BITS_PER_WORD;
    localparam int WCNT_W     = $clog2(N_WORDS_KX);

    logic [BITS_PER_WORD-1:0] rx_data;
    logic                     rx_valid;
    logic [N_BITS-1:0]        bus;
    logic [WCNT_W-1:0]        word_cnt;
    logic                     vec_done;
    logic [R*W_Y_OUT-1:0]     y;
    logic [R*W_Y_OUT-1:0]     pending_y;
    logic                     pending;
    logic                     tx_busy;
    logic                     tx_load;
    logic                     tx;
    logic                     unused_ok;

    uart_rx #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (ui_in[0]),
        .data (rx_data),
        .valid(rx_valid)
    );

    // Bytes shift in from the top so byte i ends up in bus[8i+7:8i] after a full vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus      <= '0;
            word_cnt <= '0;
            vec_done <= 1'b0;
        end else begin
            vec_done <= 1'b0;
            if (rx_valid) begin
                bus <= {rx_data, bus[N_BITS-1:BITS_PER_WORD]};
                if (word_cnt == WCNT_W'(N_WORDS_KX - 1)) begin
                    word_cnt <= '0;
                    vec_done <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    mvm #(
        .R      (R),
        .C      (C),
        .W_X    (W_X),
        .W_K    (W_K),
        .W_Y_OUT(W_Y_OUT)
    ) u_mvm (
        .bus(bus),
        .y  (y)
    );

    // A single-entry holding slot lets RX finish a vector while TX is still busy.
    assign tx_load = pending && !tx_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            pending_y <= '0;
        end else if (vec_done) begin
            pending   <= 1'b1;
            pending_y <= y;
        end else if (tx_load) begin
            pending <= 1'b0;
        end
    end

    uart_tx #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD),
        .N_WORDS         (N_WORDS_Y),
        .PACKET_SIZE_TX  (PACKET_SIZE_TX)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tx_load),
        .words(pending_y),
        .busy (tx_busy),
        .tx   (tx)
    );

    assign uo_out    = {7'b0, tx};
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in};
endmodule

// File: tb/tb_tt_um_uart_mvm.sv
// Directed and random UART vectors for tt_um_uart_mvm, checked by a tx-line decoder and scoreboard.

module tb_tt_um_uart_mvm;
    localparam int CPP = 4;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] y0;
        logic [7:0] y1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       rx_line;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    vec_t       vectors[5];

    always #5 clk = ~clk;

    assign ui_in = {7'b0, rx_line};

    tt_um_uart_mvm dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One 8N1 frame on rx, followed by extra idle-high cycles.
    task automatic applyStimulus(input logic [7:0] data, input int gap);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            repeat (CPP) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (CPP + gap) @(negedge clk);
    endtask

    function automatic logic [7:0] model_row(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input int row);
        int x0, x1, k0, k1, s;
        logic [7:0] kb;
        kb = (row == 0) ? b1 : b2;
        x0 = $signed(b0[3:0]);
        x1 = $signed(b0[7:4]);
        k0 = $signed(kb[3:0]);
        k1 = $signed(kb[7:4]);
        s  = k0 * x0 + k1 * x1;
        return 8'(s);
    endfunction

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        checkOutput("tx_idle_high", uo_out[0], 1);
    endtask

    // Decodes every frame seen on tx and scores it against the expected queue.
    initial begin
        logic [7:0] data;
        logic [7:0] expv;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uo_out[0] === 1'b0) begin
                repeat (2) @(negedge clk);
                checkOutput("tx_start_bit", uo_out[0], 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPP) @(negedge clk);
                    data[i] = uo_out[0];
                end
                for (int s = 0; s < 4; s++) begin
                    repeat (CPP) @(negedge clk);
                    checkOutput("tx_stop_bit", uo_out[0], 1);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tx_byte: got 0x%0h, expected no byte", data);
                end else begin
                    expv = exp_q.pop_front();
                    checkOutput("tx_byte", data, expv);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] b0, b1, b2;

        vectors[0] = '{b0: 8'h21, b1: 8'h43, b2: 8'h65, y0: 8'h0B, y1: 8'h11};
        vectors[1] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'h77, y0: 8'h02, y1: 8'hF2};
        vectors[2] = '{b0: 8'h88, b1: 8'h88, b2: 8'h88, y0: 8'h80, y1: 8'h80};
        vectors[3] = '{b0: 8'h7F, b1: 8'h12, b2: 8'h34, y0: 8'h05, y1: 8'h11};
        vectors[4] = '{b0: 8'h70, b1: 8'h77, b2: 8'h77, y0: 8'h31, y1: 8'h31};

        rst_n   = 1'b0;
        ena     = 1'b1;
        rx_line = 1'b1;
        uio_in  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_high", uo_out[0], 1);
        checkOutput("uo_out_upper_zero", uo_out[7:1], 0);
        checkOutput("uio_out_zero", uio_out, 0);
        checkOutput("uio_oe_zero", uio_oe, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_tx_high", uo_out[0], 1);

        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vectors[v].y0);
            exp_q.push_back(vectors[v].y1);
            applyStimulus(vectors[v].b0, 3);
            applyStimulus(vectors[v].b1, 3);
            applyStimulus(vectors[v].b2, 3);
            waitDrain(600);
        end

        // Random vectors with short gaps so RX overlaps the previous transmission.
        for (int v = 0; v < 10; v++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            exp_q.push_back(model_row(b0, b1, b2, 0));
            exp_q.push_back(model_row(b0, b1, b2, 1));
            applyStimulus(b0, $urandom_range(1, 20));
            applyStimulus(b1, $urandom_range(1, 20));
            applyStimulus(b2, $urandom_range(1, 100));
        end
        waitDrain(3000);

        // A one-cycle low glitch must not start a frame.
        @(negedge clk);
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        repeat (10) @(negedge clk);

        // Partial vector abandoned by a one-cycle reset; only the next full vector responds.
        applyStimulus(8'h21, 2);
        applyStimulus(8'h43, 2);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_tx_high", uo_out[0], 1);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        checkOutput("no_output_after_partial", uo_out[0], 1);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'hF2);
        applyStimulus(8'hFF, 5);
        applyStimulus(8'hFF, 5);
        applyStimulus(8'h77, 5);
        waitDrain(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
